parking_sensor_emulator: RTL and testbench

//   Synthesizable transmitter for the parking-lot gate sensor interface. It drives the
//   two photo-sensor lines (a = outer beam, b = inner beam) with the exact Gray-coded

---
 rtl/parking_sensor_emulator.sv | 191 +++++++++++++++++++
 tb/tb_parking_sensor_emulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_sensor_emulator.sv
// -----------------------------------------------------------------------------
// parking_sensor_emulator
//   Drives the two parking-gate photo-sensor lines with the Gray-coded beam
//   sequences produced by a car entering, exiting or balking. It also keeps
//   enter/exit tallies so that a display can be checked against them.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous active-high reset
//   cmd_valid    in   1      command request
//   cmd          in   2      00 enter, 01 exit, 10 enter-balk, 11 exit-balk
//   cmd_ready    out  1      high in IDLE; accept on cmd_valid & cmd_ready
//   a            out  1      outer beam, 1 = blocked
//   b            out  1      inner beam, 1 = blocked
//   busy         out  1      sequence in progress
//   done         out  1      one-cycle completion pulse
//   entered_cnt  out  CNT_W  completed enters, wrapping
//   exited_cnt   out  CNT_W  completed exits, wrapping
// -----------------------------------------------------------------------------
module parking_sensor_emulator #(
  parameter int unsigned DWELL_CYCLES = 11,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] entered_cnt,
  output logic [CNT_W-1:0] exited_cnt
);

  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned PHASE_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PHASE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic [1:0]         cmd_q,   cmd_d;

  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   ent_q, ent_d;
  logic [CNT_W-1:0]   ext_q, ext_d;

  // Beam pattern: exit sequences are the enter sequences with a and b swapped;
  // balks continue the same walk back out the way the car came in.
  function automatic logic [1:0] phase_ab(input logic [1:0] c,
                                          input logic [PHASE_W-1:0] p);
    logic [1:0] ab_enter;
    ab_enter = 2'b00;
    unique case (p)
      3'd0:    ab_enter = 2'b10;
      3'd1:    ab_enter = 2'b11;
      3'd2:    ab_enter = 2'b01;
      3'd3:    ab_enter = 2'b11;
      3'd4:    ab_enter = 2'b10;
      default: ab_enter = 2'b00;
    endcase
    return c[0] ? {ab_enter[0], ab_enter[1]} : ab_enter;
  endfunction

  // Index of the final phase: 3 phases for enter/exit, 5 for balks.
  function automatic logic [PHASE_W-1:0] last_phase(input logic [1:0] c);
    return c[1] ? PHASE_W'(4) : PHASE_W'(2);
  endfunction

  // State register and sequencing counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      dwell_q <= '0;
      gap_q   <= '0;
      cmd_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_PHASE;
          phase_d = '0;
          dwell_d = '0;
          cmd_d   = cmd;
        end
      end
      S_PHASE: begin
        if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
          dwell_d = '0;
          if (phase_q == last_phase(cmd_q)) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: outputs are computed from the next state so that the
  // registered lines line up exactly with the state they describe.
  always_comb begin
    a_d     = 1'b0;
    b_d     = 1'b0;
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_GAP) && (state_d == S_IDLE);
    ent_d   = ent_q;
    ext_d   = ext_q;
    if (state_d == S_PHASE) begin
      {a_d, b_d} = phase_ab(cmd_d, phase_d);
    end
    if (done_d && (cmd_q == 2'b00)) begin
      ent_d = ent_q + CNT_W'(1);
    end
    if (done_d && (cmd_q == 2'b01)) begin
      ext_d = ext_q + CNT_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      ent_q   <= '0;
      ext_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      ent_q   <= ent_d;
      ext_q   <= ext_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_ready   = ready_q;
  assign entered_cnt = ent_q;
  assign exited_cnt  = ext_q;

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// -----------------------------------------------------------------------------
// tb_parking_sensor_emulator
//   Scoreboard bench: each command pushes its full expected per-cycle trace
//   (a, b, busy, cmd_ready, done, counters) into a queue, and each DUT cycle
//   pops one entry and compares it. A second instance with CNT_W=2 and the
//   minimum dwell/gap covers counter wrap.
// -----------------------------------------------------------------------------
module tb_parking_sensor_emulator;

  localparam int unsigned DWELL = 11;
  localparam int unsigned GAP   = 2;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       ready;
    logic       done;
    logic [7:0] ent;
    logic [7:0] ext;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_valid_w;
  logic [1:0] cmd, cmd_w;
  logic       cmd_ready, a, b, busy, done;
  logic [7:0] entered_cnt, exited_cnt;
  logic       cmd_ready_w, a_w, b_w, busy_w, done_w;
  logic [1:0] entered_w, exited_w;

  exp_t       q[$];
  logic [1:0] wq[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc_no = 0;
  logic [7:0] m_ent = 8'd0;
  logic [7:0] m_ext = 8'd0;

  always #5 clk = ~clk;

  parking_sensor_emulator #(.DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .a(a), .b(b), .busy(busy), .done(done),
    .entered_cnt(entered_cnt), .exited_cnt(exited_cnt)
  );

  parking_sensor_emulator #(.DWELL_CYCLES(1), .GAP_CYCLES(1), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_w), .cmd(cmd_w),
    .cmd_ready(cmd_ready_w), .a(a_w), .b(b_w), .busy(busy_w), .done(done_w),
    .entered_cnt(entered_w), .exited_cnt(exited_w)
  );

  // Expected beam sequence for a command, written out from the gate's point of view.
  function automatic logic [1:0] model_ab(input logic [1:0] c, input int idx);
    logic [1:0] seq [5];
    case (c)
      2'b00:   seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
      2'b01:   seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
      2'b10:   seq = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
      default: seq = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
    endcase
    return seq[idx];
  endfunction

  // Push the whole expected trace of one command, starting the cycle after acceptance.
  task automatic push_seq(input logic [1:0] c);
    int   n;
    exp_t e;
    logic [1:0] ab;
    n = c[1] ? 5 : 3;
    for (int p = 0; p < n; p++) begin
      ab = model_ab(c, p);
      for (int d = 0; d < int'(DWELL); d++) begin
        e = '{a: ab[1], b: ab[0], busy: 1'b1, ready: 1'b0, done: 1'b0, ent: m_ent, ext: m_ext};
        q.push_back(e);
      end
    end
    for (int g = 0; g < int'(GAP); g++) begin
      e = '{a: 1'b0, b: 1'b0, busy: 1'b1, ready: 1'b0, done: 1'b0, ent: m_ent, ext: m_ext};
      q.push_back(e);
    end
    if (c == 2'b00) m_ent = m_ent + 8'd1;
    if (c == 2'b01) m_ext = m_ext + 8'd1;
    e = '{a: 1'b0, b: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b1, ent: m_ent, ext: m_ext};
    q.push_back(e);
  endtask

  // Pop and compare n scoreboard entries, one per clock.
  task automatic drain(input string name, input int n);
    exp_t e;
    exp_t o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc_no++;
      o = '{a: a, b: b, busy: busy, ready: cmd_ready, done: done,
            ent: entered_cnt, ext: exited_cnt};
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL %s cyc %0d: scoreboard empty, got %h", name, cyc_no, o);
      end else begin
        e = q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s cyc %0d: got a=%b b=%b busy=%b rdy=%b done=%b ent=%0d ext=%0d, want a=%b b=%b busy=%b rdy=%b done=%b ent=%0d ext=%0d",
                   name, cyc_no, o.a, o.b, o.busy, o.ready, o.done, o.ent, o.ext,
                   e.a, e.b, e.busy, e.ready, e.done, e.ent, e.ext);
        end
      end
    end
  endtask

  task automatic start_cmd(input logic [1:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    cyc_no    = 0;
    push_seq(c);
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_valid_w = 1'b0; cmd_w = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_ent = 8'd0; m_ext = 8'd0;
    e = '{a: 1'b0, b: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0, ent: 8'd0, ext: 8'd0};
    q.push_back(e);
    drain("reset_idle", 1);
    n_vec++;
    if ({a_w, b_w, busy_w, cmd_ready_w, done_w, entered_w, exited_w} !== 9'b00010_0000) begin
      n_err++;
      $display("FAIL reset_w: got %b want 000100000",
               {a_w, b_w, busy_w, cmd_ready_w, done_w, entered_w, exited_w});
    end
  endtask

  task automatic test_enter();
    start_cmd(2'b00);
    drain("enter", 1);
    cmd_valid = 1'b0;
    drain("enter", q.size());
  endtask

  task automatic test_exit_balk();
    start_cmd(2'b11);
    drain("exit_balk", 1);
    cmd_valid = 1'b0;
    drain("exit_balk", q.size());
  endtask

  // Held cmd_valid: the exit must be taken in the enter's done cycle.
  task automatic test_back_to_back();
    start_cmd(2'b00);
    push_seq(2'b01);
    drain("b2b", 1);
    cmd = 2'b01;
    drain("b2b", 35 + 35);
    cmd_valid = 1'b0;
    drain("b2b", q.size());
  endtask

  task automatic test_ignore_busy();
    start_cmd(2'b00);
    drain("ignore", 1);
    cmd_valid = 1'b0;
    drain("ignore", 20);
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    drain("ignore", 1);
    cmd_valid = 1'b0;
    drain("ignore", q.size());
  endtask

  // Reset lands in the second exit phase while cmd_valid is also high.
  task automatic test_reset_abort();
    start_cmd(2'b01);
    drain("abort", 1);
    cmd_valid = 1'b0;
    drain("abort", 15);
    q.delete();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    m_ent = 8'd0; m_ext = 8'd0;
    q.push_back('{a: 1'b0, b: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0, ent: 8'd0, ext: 8'd0});
    drain("abort_rst", 1);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    q.push_back('{a: 1'b0, b: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0, ent: 8'd0, ext: 8'd0});
    q.push_back('{a: 1'b0, b: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0, ent: 8'd0, ext: 8'd0});
    drain("abort_post", 2);
  endtask

  // CNT_W=2 instance with minimum dwell/gap: five enters wrap the tally.
  task automatic test_wrap();
    int cyc;
    logic [1:0] ex;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cmd_valid_w = 1'b1;
      cmd_w       = 2'b00;
      wq.push_back(2'(k));
      @(posedge clk);
      #1;
      cmd_valid_w = 1'b0;
      cyc = 1;
      while (done_w !== 1'b1 && cyc < 20) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      ex = wq.pop_front();
      n_vec++;
      if (cyc != 5 || done_w !== 1'b1) begin
        n_err++;
        $display("FAIL wrap_done k=%0d: done=%b at cycle %0d, want done=1 at cycle 5", k, done_w, cyc);
      end
      n_vec++;
      if (entered_w !== ex || exited_w !== 2'd0 || cmd_ready_w !== 1'b1) begin
        n_err++;
        $display("FAIL wrap_cnt k=%0d: ent=%0d ext=%0d rdy=%b, want ent=%0d ext=0 rdy=1",
                 k, entered_w, exited_w, cmd_ready_w, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enter();
    test_exit_balk();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
